// File: rtl/div_sched.sv
// Iterative radix-2 restoring divider controller for div.w/mod.w/div.wu/mod.wu.
// A request passes through PREP, W CALC cycles and FIX, then waits in DONE until the consumer takes it.
module div_sched #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_signed,
  input  logic         in_quot,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  input  logic         flush,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] CALC = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dmag_q, dmag_d;
  logic [W-1:0]   res_q, res_d;
  logic           sgn_q, sgn_d;
  logic           quot_q, quot_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;

  logic [W:0]     sh;
  logic [W+1:0]   diff;
  logic           borrow;
  logic           unused_diff;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;

  // Shifted partial remainder can reach 2*divisor-1, hence the extra bit.
  assign sh          = {rem_q, quo_q[W-1]};
  assign diff        = {1'b0, sh} - {2'b0, dmag_q};
  assign borrow      = diff[W+1];
  assign unused_diff = diff[W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    res_d   = res_q;
    sgn_d   = sgn_q;
    quot_d  = quot_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          a_d     = in_dividend;
          b_d     = in_divisor;
          sgn_d   = in_signed;
          quot_d  = in_quot;
          state_d = PREP;
        end
      end
      PREP: begin
        quo_d  = (sgn_q && a_q[W-1]) ? -a_q : a_q;
        dmag_d = (sgn_q && b_q[W-1]) ? -b_q : b_q;
        qneg_d = sgn_q && (a_q[W-1] ^ b_q[W-1]);
        rneg_d = sgn_q && a_q[W-1];
        rem_d  = '0;
        cnt_d  = '0;
        if (b_q == '0) begin
          res_d   = quot_q ? '1 : a_q;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = borrow ? sh[W-1:0] : diff[W-1:0];
        quo_d = {quo_q[W-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) state_d = FIX;
      end
      FIX: begin
        if (quot_q) res_d = qneg_q ? -quo_q : quo_q;
        else        res_d = rneg_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      res_q   <= '0;
      sgn_q   <= 1'b0;
      quot_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      res_q   <= res_d;
      sgn_q   <= sgn_d;
      quot_q  <= quot_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule
